// File: rtl/tcdm36_bank_ctrl.sv
// Slave controller for one 36-bit TCDM bank (8 data + 1 tag bit per byte).
// After reset it sweeps the bank to a known tag value, then serves single-cycle requests and counts tagged reads.
module tcdm36_bank_ctrl #(
  parameter int unsigned NUM_WORDS  = 1024,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_WORDS),
  parameter int unsigned MEM_LAT    = 1,
  parameter logic        INIT_TAG   = 1'b1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tcdm_req_i,
  input  logic [31:0]           tcdm_add_i,
  input  logic                  tcdm_wen_i,
  input  logic [3:0]            tcdm_be_i,
  input  logic [35:0]           tcdm_wdata_i,
  output logic                  tcdm_gnt_o,
  output logic                  tcdm_r_valid_o,
  output logic                  tcdm_r_opc_o,
  output logic [35:0]           tcdm_r_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [35:0]           mem_bwe_o,
  output logic [35:0]           mem_wdata_o,
  input  logic [35:0]           mem_rdata_i,
  output logic                  init_done_o,
  input  logic                  tag_cnt_clr_i,
  output logic [CNT_WIDTH-1:0]  tag_cnt_o,
  output logic                  fsm_state_o
);

  // Handshake: in RUN a request is accepted in the cycle tcdm_req_i is high (gnt
  // mirrors req); its response shows r_valid for exactly one cycle MEM_LAT cycles
  // later. There is no backpressure on either side.

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
  logic [MEM_LAT-1:0]    pv_q, pv_d, po_q, po_d, pr_q, pr_d;
  logic [35:0]           rdata_q, rdata_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic        in_range;
  logic        accept;
  logic        rsp_valid, rsp_opc, rsp_read;
  logic        rsp_tagged;
  logic [35:0] rsp_rdata;
  logic [35:0] init_wdata;
  logic        unused_add;

  assign unused_add = ^tcdm_add_i[1:0];
  assign in_range   = (tcdm_add_i[31:ADDR_WIDTH+2] == '0);

  always_comb begin
    init_wdata     = '0;
    init_wdata[8]  = INIT_TAG;
    init_wdata[17] = INIT_TAG;
    init_wdata[26] = INIT_TAG;
    init_wdata[35] = INIT_TAG;
  end

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    accept      = 1'b0;
    tcdm_gnt_o  = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_bwe_o   = '0;
    mem_wdata_o = '0;
    case (state_q)
      ST_INIT: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_bwe_o   = '1;
        mem_addr_o  = sweep_q;
        mem_wdata_o = init_wdata;
        if (sweep_q == ADDR_WIDTH'(NUM_WORDS - 1)) begin
          state_d = ST_RUN;
        end else begin
          sweep_d = sweep_q + ADDR_WIDTH'(1);
        end
      end
      ST_RUN: begin
        tcdm_gnt_o  = tcdm_req_i;
        accept      = tcdm_req_i;
        mem_addr_o  = tcdm_add_i[ADDR_WIDTH+1:2];
        mem_wdata_o = tcdm_wdata_i;
        // Out-of-range requests are granted but never touch the macro.
        if (tcdm_req_i && in_range) begin
          mem_req_o = 1'b1;
          mem_we_o  = ~tcdm_wen_i;
          for (int k = 0; k < 4; k++) begin
            mem_bwe_o[9*k +: 9] = {9{tcdm_be_i[k] & ~tcdm_wen_i}};
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    pv_d    = '0;
    po_d    = '0;
    pr_d    = '0;
    pv_d[0] = accept;
    po_d[0] = accept & ~in_range;
    pr_d[0] = accept & tcdm_wen_i;
    for (int i = 1; i < MEM_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      po_d[i] = po_q[i-1];
      pr_d[i] = pr_q[i-1];
    end
  end

  assign rsp_valid = pv_q[MEM_LAT-1];
  assign rsp_opc   = po_q[MEM_LAT-1];
  assign rsp_read  = pr_q[MEM_LAT-1];

  // Read data arrives from the macro in the response cycle itself, so it is
  // steered straight through; outside a response the last value is held.
  assign rsp_rdata  = (rsp_valid & rsp_read & ~rsp_opc) ? mem_rdata_i : '0;
  assign rsp_tagged = rsp_valid & rsp_read & ~rsp_opc &
                      (mem_rdata_i[8] | mem_rdata_i[17] | mem_rdata_i[26] | mem_rdata_i[35]);

  always_comb begin
    rdata_d = rdata_q;
    if (rsp_valid) begin
      rdata_d = rsp_rdata;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (tag_cnt_clr_i) begin
      cnt_d = '0;
    end else if (rsp_tagged && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      pv_q    <= '0;
      po_q    <= '0;
      pr_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      pv_q    <= pv_d;
      po_q    <= po_d;
      pr_q    <= pr_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tcdm_r_valid_o = rsp_valid;
  assign tcdm_r_opc_o   = rsp_valid & rsp_opc;
  assign tcdm_r_rdata_o = rsp_valid ? rsp_rdata : rdata_q;
  assign init_done_o    = (state_q == ST_RUN);
  assign tag_cnt_o      = cnt_q;
  assign fsm_state_o    = state_q;

endmodule

// File: tb/tb_tcdm36_bank_ctrl.sv
// Directed bench for tcdm36_bank_ctrl: 16-word bank, 2-cycle SRAM model, 2-bit tag counter.
// Responses are checked by a monitor popping an expected queue filled at issue time.
module tb_tcdm36_bank_ctrl;
  localparam int NW  = 16;
  localparam int AW  = 4;
  localparam int LAT = 2;
  localparam int CW  = 2;
  localparam logic [35:0] INIT_W = 36'h8_0402_0100;

  logic          clk, rst_n;
  logic          req, wen, gnt, r_valid, r_opc;
  logic [31:0]   add;
  logic [3:0]    be;
  logic [35:0]   wdata, r_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [35:0]   mem_bwe, mem_wdata, mem_rdata;
  logic          init_done, clr, fsm_state;
  logic [CW-1:0] tag_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  logic [36:0] exp_q[$];
  int          due_q[$];

  tcdm36_bank_ctrl #(
    .NUM_WORDS(NW), .ADDR_WIDTH(AW), .MEM_LAT(LAT), .INIT_TAG(1'b1), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tcdm_req_i(req), .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_wdata_i(wdata),
    .tcdm_gnt_o(gnt), .tcdm_r_valid_o(r_valid), .tcdm_r_opc_o(r_opc), .tcdm_r_rdata_o(r_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_bwe_o(mem_bwe),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .init_done_o(init_done), .tag_cnt_clr_i(clr), .tag_cnt_o(tag_cnt), .fsm_state_o(fsm_state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // SRAM model: bit-masked writes, reads visible LAT cycles after the request
  logic [35:0] sram [NW];
  logic [35:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (mem_req && mem_we) sram[mem_addr] <= (sram[mem_addr] & ~mem_bwe) | (mem_wdata & mem_bwe);
    rd_pipe[0] <= (mem_req && !mem_we) ? sram[mem_addr] : 36'hD_EAD0_BEEF;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [36:0] e;
    int d;
    if (rst_n && r_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid actual=%h expected=none t=%0t", {r_opc, r_rdata}, $time);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        chk("rsp_data", 64'({r_opc, r_rdata}), 64'(e));
        chk("rsp_latency", 64'(cyc_n), 64'(d));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // driver: one granted request, checks the SRAM-side view of it
  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [35:0] wd, input logic [35:0] exp_bwe, input logic [35:0] exp_rd);
    logic oor;
    oor   = (a[31:AW+2] != '0);
    req   = 1'b1;
    add   = a;
    wen   = w;
    be    = b;
    wdata = wd;
    #1;
    chk("gnt", 64'(gnt), 64'(1));
    chk("mem_req", 64'(mem_req), 64'(!oor));
    if (!oor) begin
      chk("mem_addr", 64'(mem_addr), 64'(a[AW+1:2]));
      chk("mem_we", 64'(mem_we), 64'(!w));
      chk("mem_bwe", 64'(mem_bwe), 64'(exp_bwe));
      chk("mem_wdata", 64'(mem_wdata), 64'(wd));
    end
    exp_q.push_back({oor, exp_rd});
    due_q.push_back(cyc_n + LAT);
    cyc();
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("idle_mem", 64'({mem_req, mem_we, mem_bwe}), 64'(0));
      cyc();
    end
  endtask

  // init sweep of n cycles starting from address 0, with a pending request that must not be granted
  task automatic sweep(input int n);
    req = 1'b1;
    add = 32'h0;
    wen = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("init_gnt", 64'(gnt), 64'(0));
      chk("init_done_low", 64'(init_done), 64'(0));
      chk("init_addr", 64'(mem_addr), 64'(i));
      chk("init_ctrl", 64'({mem_req, mem_we, mem_bwe}), 64'({2'b11, 36'hF_FFFF_FFFF}));
      chk("init_wdata", 64'(mem_wdata), 64'(INIT_W));
      if (i == n - 1) req = 1'b0;
      cyc();
    end
  endtask

  task automatic reset_outputs_check();
    chk("rst_ctl", 64'({gnt, r_valid, r_opc, init_done, fsm_state}), 64'(0));
    chk("rst_cnt", 64'(tag_cnt), 64'(0));
    chk("rst_rdata", 64'(r_rdata), 64'(0));
  endtask

  initial begin
    req = 0; add = 0; wen = 1; be = 0; wdata = 0; clr = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_outputs_check();
    rst_n = 1'b1;

    sweep(NW);
    #1;
    chk("init_done", 64'({init_done, fsm_state}), 64'(2'b11));
    cyc();

    // writes: partial lanes 0/2, then a full untagged word
    issue(32'h8, 1'b0, 4'b0101, 36'h1_2345_6789, 36'h0_07FC_01FF, 36'h0);
    issue(32'hC, 1'b0, 4'b1111, 36'h0_1234_5678, 36'hF_FFFF_FFFF, 36'h0);
    idle(4);
    chk("cnt_after_writes", 64'(tag_cnt), 64'(0));

    issue(32'h14, 1'b1, 4'b1111, 36'h0, 36'h0, INIT_W);
    idle(3);
    chk("cnt_fresh_read", 64'(tag_cnt), 64'(1));
    issue(32'hC, 1'b1, 4'b1111, 36'h0, 36'h0, 36'h0_1234_5678);
    idle(3);
    chk("cnt_untagged_read", 64'(tag_cnt), 64'(1));
    issue(32'h8, 1'b1, 4'b1111, 36'h0, 36'h0, 36'h8_0346_0189);
    idle(3);
    chk("cnt_partial_word", 64'(tag_cnt), 64'(2));

    // out-of-range read and write: error response, no SRAM access
    issue(32'h40, 1'b1, 4'b1111, 36'h0, 36'h0, 36'h0);
    issue(32'h400, 1'b0, 4'b1111, 36'h3_3333_3333, 36'h0, 36'h0);
    idle(4);
    chk("cnt_oor", 64'(tag_cnt), 64'(2));

    // back-to-back reads in order; counter saturates at 3
    issue(32'h8, 1'b1, 4'b1111, 36'h0, 36'h0, 36'h8_0346_0189);
    issue(32'hC, 1'b1, 4'b1111, 36'h0, 36'h0, 36'h0_1234_5678);
    issue(32'h10, 1'b1, 4'b1111, 36'h0, 36'h0, INIT_W);
    issue(32'h14, 1'b1, 4'b1111, 36'h0, 36'h0, INIT_W);
    idle(3);
    chk("cnt_saturated", 64'(tag_cnt), 64'(3));
    chk("rdata_hold", 64'({r_valid, r_rdata}), 64'({1'b0, INIT_W}));

    // clear, then clear colliding with a tagged response
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    #1;
    chk("cnt_clr", 64'(tag_cnt), 64'(0));
    issue(32'h20, 1'b1, 4'b1111, 36'h0, 36'h0, INIT_W);
    idle(3);
    chk("cnt_after_clr", 64'(tag_cnt), 64'(1));
    issue(32'h24, 1'b1, 4'b1111, 36'h0, 36'h0, INIT_W);
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    #1;
    chk("cnt_clr_wins", 64'(tag_cnt), 64'(0));
    cyc();

    // five tagged reads with a 2-bit counter
    for (int i = 10; i < 15; i++) issue(32'(i * 4), 1'b1, 4'b1111, 36'h0, 36'h0, INIT_W);
    idle(3);
    chk("cnt_five_tagged", 64'(tag_cnt), 64'(3));

    // reset with a read in flight, then reset again mid-sweep
    issue(32'h8, 1'b1, 4'b1111, 36'h0, 36'h0, 36'h8_0346_0189);
    rst_n = 1'b0;
    exp_q.delete();
    due_q.delete();
    #1;
    reset_outputs_check();
    cyc();
    cyc();
    rst_n = 1'b1;
    sweep(6);
    rst_n = 1'b0;
    #1;
    reset_outputs_check();
    cyc();
    rst_n = 1'b1;
    sweep(NW);
    #1;
    chk("reinit_done", 64'({init_done, fsm_state}), 64'(2'b11));
    cyc();
    issue(32'h8, 1'b1, 4'b1111, 36'h0, 36'h0, INIT_W);
    idle(3);
    chk("cnt_after_reinit", 64'(tag_cnt), 64'(1));

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) cyc();
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
